// File: rtl/example_pkg.sv
// Shared types and constants for the example stream blocks.
package example_pkg;

    localparam int EXAMPLE_DATA_W     = 5;
    localparam int EXAMPLE_FIFO_DEPTH = 4;

    typedef logic [EXAMPLE_DATA_W-1:0] example_type_t;

    // One stream beat: valid qualifies data.
    typedef struct packed {
        logic          valid;
        example_type_t data;
    } example_struct_s;

endpackage : example_pkg

// File: rtl/example_fifo_mem.sv
// Register-array storage for example_fifo: one write port, one async read port.
// Contents are deliberately not reset; only the FIFO pointers define validity.
module example_fifo_mem
    import example_pkg::*;
#(
    parameter int DEPTH = EXAMPLE_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  example_type_t wdata,
    input  logic [AW-1:0] raddr,
    output example_type_t rdata
);

    example_type_t mem_q [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : example_fifo_mem

// File: rtl/example_fifo.sv
// First-word-fall-through FIFO for example_struct_s beats with valid/ready handshake.
// Pointers carry one extra wrap bit so full and empty are distinguishable without
// a separate occupancy register; count falls out of modular pointer subtraction.
module example_fifo
    import example_pkg::*;
#(
    parameter int DEPTH = EXAMPLE_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  example_struct_s          i_in,
    output logic                     o_in_ready,
    output example_struct_s          o_out,
    input  logic                     i_out_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    example_type_t rdata;

    // Flags depend only on registered pointers, so ready never sees i_out_ready.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign push = i_in.valid && !full;
    assign pop  = !empty && i_out_ready;

    // Advance pointers on accepted handshakes; wrap is plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer registers; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    example_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (i_in.data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rdata)
    );

    // Head beat is forced to zero when empty so stale storage never leaks out.
    always_comb begin
        o_out       = '0;
        o_out.valid = !empty;
        if (!empty) begin
            o_out.data = rdata;
        end
    end

    assign o_count    = wr_ptr_q - rd_ptr_q;
    assign o_full     = full;
    assign o_empty    = empty;
    assign o_in_ready = !full;

endmodule : example_fifo
